// File: rtl/im_loader_pkg.sv
// Loader state codes and the frame-length bounds check shared by the IM loader.
// Pure declarations; no logic or latency of its own.
// No flow control here.
package im_loader_pkg;

  typedef enum logic [2:0] {
    L_LEN_HI = 3'd0,
    L_LEN_LO = 3'd1,
    L_DATA   = 3'd2,
    L_CHK    = 3'd3,
    L_DONE   = 3'd4,
    L_ERR    = 3'd5
  } ld_state_e;

  // Per-frame bookkeeping held by the loader between bytes.
  typedef struct packed {
    logic [15:0] len;
    logic [7:0]  chk;
    logic [15:0] words;
  } ld_meta_t;

  localparam ld_meta_t LD_META_RST = '{len: 16'd0, chk: 8'd0, words: 16'd0};

  // True when a frame of len words starting at base_idx stays inside a 2**addr_w deep IM.
  function automatic logic len_fits(input logic [15:0] len, input int addr_w, input int base_idx);
    return (32'(len) <= ((32'd1 << addr_w) - 32'(base_idx)));
  endfunction

endpackage

// File: rtl/im_loader_byte_packer.sv
// Packs stream bytes MSB-first into 32-bit words and flags each completed word.
// word_vld rises 1 clk after the 4th byte is accepted; word_dat holds that word for the pulse.
// No backpressure of its own; accepts a byte whenever byte_vld is high.
module im_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_end,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [1:0] cnt;

  // High while the next accepted byte completes a word.
  assign word_end = (cnt == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= 2'd0;
      word_vld <= 1'b0;
      word_dat <= 32'd0;
    end else if (clr) begin
      cnt      <= 2'd0;
      word_vld <= 1'b0;
      word_dat <= 32'd0;
    end else begin
      word_vld <= byte_vld & word_end;
      if (byte_vld) begin
        cnt      <= cnt + 2'd1;
        word_dat <= {word_dat[23:0], byte_dat};
      end
    end
  end

endmodule

// File: rtl/im_loader.sv
// Streams a length-prefixed, XOR-checksummed image into IM, then releases the CPU from reset.
// IM write strobe arrives 1 clk after the 4th byte of each word; status outputs follow state by 0 clk.
// in_ready is a decode of registered state only; it drops in DONE/ERR until restart or reset.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int BASE_IDX = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_done
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_IDX);

  ld_state_e         state, nxt;
  ld_meta_t          meta;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       words_next;
  logic [15:0]       len_rx;
  logic              xfer, take, data_byte, word_end;

  assign xfer       = in_valid & in_ready;
  assign take       = xfer & ~restart;
  assign data_byte  = take & (state == L_DATA);
  assign words_next = meta.words + 16'd1;
  assign len_rx     = {meta.len[15:8], in_data};

  im_loader_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (restart),
    .byte_vld (data_byte),
    .byte_dat (in_data),
    .word_end (word_end),
    .word_vld (im_we),
    .word_dat (im_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= L_LEN_HI;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (restart) begin
      nxt = L_LEN_HI;
    end else if (xfer) begin
      unique case (state)
        L_LEN_HI: nxt = L_LEN_LO;
        L_LEN_LO: begin
          if (len_rx == 16'd0)                          nxt = L_CHK;
          else if (!len_fits(len_rx, ADDR_W, BASE_IDX)) nxt = L_ERR;
          else                                          nxt = L_DATA;
        end
        L_DATA:   if (word_end && (words_next == meta.len)) nxt = L_CHK;
        L_CHK:    nxt = (in_data == meta.chk) ? L_DONE : L_ERR;
        default:  nxt = state;
      endcase
    end
  end

  always_comb begin
    in_ready = (state != L_DONE) && (state != L_ERR);
    done     = (state == L_DONE);
    err      = (state == L_ERR);
    cpu_rst  = (state != L_DONE);
  end

  // Address and word count advance on the byte that completes a word, so they line up with im_we.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta   <= LD_META_RST;
      addr_q <= BASE;
    end else if (restart) begin
      meta   <= LD_META_RST;
      addr_q <= BASE;
    end else if (take) begin
      unique case (state)
        L_LEN_HI: meta.len[15:8] <= in_data;
        L_LEN_LO: meta.len[7:0]  <= in_data;
        L_DATA: begin
          meta.chk <= meta.chk ^ in_data;
          if (word_end) begin
            addr_q     <= BASE + ADDR_W'(meta.words);
            meta.words <= words_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign im_addr    = addr_q;
  assign words_done = meta.words;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: frames, checksum errors, overflow, stalls, restart and async reset.
module tb_im_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              restart = 1'b0;
  logic              mem_clr = 1'b0;
  logic              in_ready, im_we, cpu_rst, done, err;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [15:0]       words_done;

  logic [31:0] mem [0:DEPTH-1];
  int          we_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  fr [$];

  im_loader #(.ADDR_W(ADDR_W), .BASE_IDX(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .restart    (restart),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err),
    .words_done (words_done)
  );

  always #5 clk = ~clk;

  // Instruction memory model: the write port the loader drives.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hDEADBEEF;
    end else if (im_we === 1'b1) begin
      mem[im_addr] <= im_wdata;
    end
    if (im_we === 1'b1) we_cnt <= we_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic clear_mem();
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
  endtask

  // Frame 1 with either its true checksum or a forced checksum byte.
  task automatic build_frame1(input bit force_chk, input logic [7:0] chk_byte);
    logic [7:0] x;
    fr = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h24, 8'h09, 8'h00, 8'h07};
    x = 8'h00;
    for (int i = 2; i < fr.size(); i++) x = x ^ fr[i];
    fr.push_back(force_chk ? chk_byte : x);
  endtask

  // Sends fr; checks each write strobe lands 1 clk after its 4th byte, and lasts one cycle.
  task automatic send_frame(input bit gap, input string tag);
    int npay;
    bool_loop: for (int i = 0; i < fr.size(); i++) begin
      npay = fr.size() - 3;
      send_byte(fr[i]);
      if (i >= 2 && i < 2 + npay && ((i - 2) % 4) == 3) begin
        check({tag, " we_lat"}, 32'(im_we), 32'd1);
        check({tag, " we_addr"}, 32'(im_addr), 32'((i - 2) / 4));
        if (gap) begin
          tick();
          check({tag, " we_pulse"}, 32'(im_we), 32'd0);
        end
      end else if (gap) begin
        tick();
      end
    end
  endtask

  task automatic check_frame1_ok(input string tag);
    check({tag, " im0"}, mem[0], 32'h24080005);
    check({tag, " im1"}, mem[1], 32'h24090007);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " err"}, 32'(err), 32'd0);
    check({tag, " cpu_rst"}, 32'(cpu_rst), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    check({tag, " words"}, 32'(words_done), 32'd2);
  endtask

  initial begin
    int base;

    // Reset state
    tick();
    tick();
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst im_we", 32'(im_we), 32'd0);
    check("rst im_addr", 32'(im_addr), 32'd0);
    check("rst im_wdata", im_wdata, 32'd0);
    check("rst cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst words", 32'(words_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Test 1: good two-word frame
    clear_mem();
    base = we_cnt;
    build_frame1(1'b0, 8'h00);
    check("t1 chk byte", 32'(fr[10]), 32'h03);
    send_frame(1'b0, "t1");
    tick();
    check_frame1_ok("t1");
    check("t1 we count", 32'(we_cnt - base), 32'd2);

    // Test 2: bad checksum, words stay written
    pulse_restart();
    check("t2 restart in_ready", 32'(in_ready), 32'd1);
    check("t2 restart cpu_rst", 32'(cpu_rst), 32'd1);
    check("t2 restart done", 32'(done), 32'd0);
    clear_mem();
    build_frame1(1'b1, 8'h08);
    send_frame(1'b0, "t2");
    tick();
    check("t2 err", 32'(err), 32'd1);
    check("t2 done", 32'(done), 32'd0);
    check("t2 cpu_rst", 32'(cpu_rst), 32'd1);
    check("t2 in_ready", 32'(in_ready), 32'd0);
    check("t2 im0", mem[0], 32'h24080005);
    check("t2 im1", mem[1], 32'h24090007);

    // Test 3: LEN one past IM depth is rejected with no writes
    pulse_restart();
    base = we_cnt;
    send_byte(8'h04);
    send_byte(8'h01);
    check("t3 err", 32'(err), 32'd1);
    check("t3 in_ready", 32'(in_ready), 32'd0);
    check("t3 cpu_rst", 32'(cpu_rst), 32'd1);
    send_byte(8'h24);
    repeat (4) tick();
    check("t3 no writes", 32'(we_cnt - base), 32'd0);
    check("t3 err sticky", 32'(err), 32'd1);

    // Empty frame goes straight to the checksum byte
    pulse_restart();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("len0 done", 32'(done), 32'd1);
    check("len0 cpu_rst", 32'(cpu_rst), 32'd0);
    check("len0 words", 32'(words_done), 32'd0);

    // Test 4: stalled stream, in_valid every other cycle
    pulse_restart();
    clear_mem();
    base = we_cnt;
    build_frame1(1'b0, 8'h00);
    send_frame(1'b1, "t4");
    check_frame1_ok("t4");
    check("t4 we count", 32'(we_cnt - base), 32'd2);

    // Test 5: restart with a same-cycle byte mid-DATA
    pulse_restart();
    clear_mem();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h24);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h05);
    check("t5 words mid", 32'(words_done), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    restart  = 1'b1;
    tick();
    in_valid = 1'b0;
    restart  = 1'b0;
    check("t5 words cleared", 32'(words_done), 32'd0);
    check("t5 im_we", 32'(im_we), 32'd0);
    check("t5 im_wdata", im_wdata, 32'd0);
    check("t5 in_ready", 32'(in_ready), 32'd1);
    build_frame1(1'b0, 8'h00);
    send_frame(1'b0, "t5");
    tick();
    check_frame1_ok("t5");

    // Test 6: async reset between clock edges after the 5th byte
    pulse_restart();
    clear_mem();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h24);
    send_byte(8'h08);
    send_byte(8'h00);
    check("t6 wdata before", im_wdata, 32'h00240800);
    #3;
    rst = 1'b0;
    #1;
    check("t6 async wdata", im_wdata, 32'd0);
    check("t6 async cpu_rst", 32'(cpu_rst), 32'd1);
    check("t6 async in_ready", 32'(in_ready), 32'd1);
    check("t6 async words", 32'(words_done), 32'd0);
    check("t6 async addr", 32'(im_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    build_frame1(1'b0, 8'h00);
    send_frame(1'b0, "t6");
    tick();
    check_frame1_ok("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
